// File: rtl/seg10_pkg.sv
// rtl/seg10_pkg.sv - shared widths and helpers for the seg10 scan controller
package seg10_pkg;

    localparam int DIGIT_W  = 4;
    localparam int BRIGHT_W = 4;

    // Digit index width; never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg10_digit_bank.sv
// rtl/seg10_digit_bank.sv - double-buffered digit value bank with atomic commit
module seg10_digit_bank
    import seg10_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int AW         = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [DIGIT_W-1:0] wr_data,
    input  logic               commit,
    input  logic [AW-1:0]      rd_idx,
    output logic [DIGIT_W-1:0] rd_data
);

    logic [DIGIT_W-1:0] shadow_q [NUM_DIGITS];
    logic [DIGIT_W-1:0] active_q [NUM_DIGITS];

    // Out-of-range addresses match no slot, so such writes fall away silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_en && (wr_addr == AW'(i))) begin
                    shadow_q[i] <= wr_data;
                end
                if (commit) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign rd_data = active_q[rd_idx];

endmodule

// File: rtl/seg10_scan_ctrl.sv
// rtl/seg10_scan_ctrl.sv - time-multiplexed digit scan with blanking and PWM brightness
module seg10_scan_ctrl
    import seg10_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_WIDTH  = 10,
    parameter int BLANK_CYCLES = 16,
    localparam int AW          = addr_width(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DIGIT_W-1:0]    wr_data,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGIT_W-1:0]    count,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  sync
);

    localparam logic [AW-1:0]          IDX_LAST  = AW'(NUM_DIGITS - 1);
    localparam logic [DWELL_WIDTH-1:0] BLANK_END = DWELL_WIDTH'(BLANK_CYCLES);

    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic [BRIGHT_W-1:0]    bright_q, bright_d;
    logic                   slot_end, frame_end, wr_fire, lit;

    always_comb begin
        slot_end  = &dwell_q;
        frame_end = slot_end && (idx_q == IDX_LAST);
        dwell_d   = dwell_q + 1'b1;
        idx_d     = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        bright_d  = frame_end ? brightness : bright_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_q  <= '0;
            idx_q    <= '0;
            bright_q <= '0;
        end else begin
            dwell_q  <= dwell_d;
            idx_q    <= idx_d;
            bright_q <= bright_d;
        end
    end

    // Writes are refused only on the commit cycle so a commit never races a write.
    assign wr_ready = !frame_end;
    assign wr_fire  = wr_valid && wr_ready;

    seg10_digit_bank #(
        .NUM_DIGITS (NUM_DIGITS),
        .AW         (AW)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_fire),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .commit  (frame_end),
        .rd_idx  (idx_q),
        .rd_data (count)
    );

    // Top four dwell bits form a 16-step PWM ramp inside each slot.
    assign lit      = (dwell_q >= BLANK_END)
                   && (dwell_q[DWELL_WIDTH-1 -: BRIGHT_W] < bright_q);
    assign digit_en = lit ? (NUM_DIGITS'(1) << idx_q) : '0;
    assign sync     = (idx_q == '0) && (dwell_q == '0);

endmodule

// File: tb/tb_seg10_scan_ctrl.sv
// tb/tb_seg10_scan_ctrl.sv - directed table-driven bench for seg10_scan_ctrl
module tb_seg10_scan_ctrl;

    typedef struct {
        int         cyc;
        logic [3:0] count;
        logic [3:0] en;
        logic       sync;
        logic       ready;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid, wr_ready, sync;
    logic [1:0] wr_addr;
    logic [3:0] wr_data, brightness, count, digit_en;

    logic       wr_valid3, wr_ready3, sync3;
    logic [1:0] wr_addr3;
    logic [3:0] wr_data3, brightness3, count3;
    logic [2:0] digit_en3;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    seg10_scan_ctrl #(.NUM_DIGITS(4), .DWELL_WIDTH(6), .BLANK_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .brightness(brightness),
        .count(count), .digit_en(digit_en), .sync(sync)
    );

    seg10_scan_ctrl #(.NUM_DIGITS(3), .DWELL_WIDTH(6), .BLANK_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid3), .wr_ready(wr_ready3),
        .wr_addr(wr_addr3), .wr_data(wr_data3), .brightness(brightness3),
        .count(count3), .digit_en(digit_en3), .sync(sync3)
    );

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int c, input logic [3:0] cnt, input logic [3:0] en,
                       input logic s, input logic r);
        vec_t v;
        v.cyc = c; v.count = cnt; v.en = en; v.sync = s; v.ready = r;
        vecs.push_back(v);
    endtask

    task automatic drive_a(input int c);
        if (c < 256)      brightness = 4'd15;
        else if (c < 512) brightness = 4'd8;
        else if (c < 768) brightness = 4'd0;
        else              brightness = 4'd15;
        wr_valid = 1'b0;
        wr_addr  = 2'd0;
        wr_data  = 4'd0;
        if (c == 100) begin
            wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 4'd7;
        end else if (c == 254) begin
            wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 4'd5;
        end else if (c == 255 || c == 256) begin
            wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 4'd9;
        end
    endtask

    initial begin
        int k;
        reset       = 1'b1;
        wr_valid    = 1'b0; wr_addr  = '0; wr_data  = '0; brightness  = '0;
        wr_valid3   = 1'b0; wr_addr3 = '0; wr_data3 = '0; brightness3 = '0;

        // Frame 0 dark (bright_q cleared), frame 1 at 15, frame 2 at 8, frame 3 at 0, frame 4 at 15.
        add(0,    4'd0, 4'b0000, 1'b1, 1'b1);
        add(3,    4'd0, 4'b0000, 1'b0, 1'b1);
        add(150,  4'd0, 4'b0000, 1'b0, 1'b1);
        add(254,  4'd0, 4'b0000, 1'b0, 1'b1);
        add(255,  4'd0, 4'b0000, 1'b0, 1'b0);
        add(256,  4'd0, 4'b0000, 1'b1, 1'b1);
        add(258,  4'd0, 4'b0000, 1'b0, 1'b1);
        add(259,  4'd0, 4'b0001, 1'b0, 1'b1);
        add(315,  4'd0, 4'b0001, 1'b0, 1'b1);
        add(316,  4'd0, 4'b0000, 1'b0, 1'b1);
        add(323,  4'd5, 4'b0010, 1'b0, 1'b1);
        add(384,  4'd7, 4'b0000, 1'b0, 1'b1);
        add(387,  4'd7, 4'b0100, 1'b0, 1'b1);
        add(447,  4'd7, 4'b0000, 1'b0, 1'b1);
        add(448,  4'd0, 4'b0000, 1'b0, 1'b1);
        add(511,  4'd0, 4'b0000, 1'b0, 1'b0);
        add(512,  4'd0, 4'b0000, 1'b1, 1'b1);
        add(515,  4'd0, 4'b0001, 1'b0, 1'b1);
        add(543,  4'd0, 4'b0001, 1'b0, 1'b1);
        add(544,  4'd0, 4'b0000, 1'b0, 1'b1);
        add(579,  4'd9, 4'b0010, 1'b0, 1'b1);
        add(607,  4'd9, 4'b0010, 1'b0, 1'b1);
        add(608,  4'd9, 4'b0000, 1'b0, 1'b1);
        add(835,  4'd9, 4'b0000, 1'b0, 1'b1);
        add(906,  4'd7, 4'b0000, 1'b0, 1'b1);
        add(1174, 4'd7, 4'b0100, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        k = 0;
        for (int c = 0; c <= 1174; c++) begin
            drive_a(c);
            while (k < vecs.size() && vecs[k].cyc == c) begin
                chk("count",    c, 32'(count),    32'(vecs[k].count));
                chk("digit_en", c, 32'(digit_en), 32'(vecs[k].en));
                chk("sync",     c, 32'(sync),     32'(vecs[k].sync));
                chk("wr_ready", c, 32'(wr_ready), 32'(vecs[k].ready));
                k++;
            end
            if (c < 1174) step();
        end

        // Asynchronous reset in the middle of a lit digit 2 slot.
        reset = 1'b1;
        #1;
        chk("rst_count",    1174, 32'(count),    32'd0);
        chk("rst_digit_en", 1174, 32'(digit_en), 32'd0);
        chk("rst_sync",     1174, 32'(sync),     32'd1);
        chk("rst_wr_ready", 1174, 32'(wr_ready), 32'd1);
        chk("rst_sync3",    1174, 32'(sync3),    32'd1);
        wr_valid   = 1'b0;
        brightness = 4'd15;
        step();
        step();
        reset = 1'b0;

        for (int c = 0; c <= 387; c++) begin
            brightness3 = 4'd15;
            wr_valid3   = (c == 5);
            wr_addr3    = 2'd3;
            wr_data3    = 4'd4;
            if (c == 0) begin
                chk("re_sync",      c, 32'(sync),     32'd1);
                chk("re_digit_en",  c, 32'(digit_en), 32'd0);
            end
            if (c == 3)   chk("re_dark",     c, 32'(digit_en), 32'd0);
            if (c == 387) begin
                chk("re_count_cleared", c, 32'(count),    32'd0);
                chk("re_digit_en2",     c, 32'(digit_en), 32'b0100);
            end
            if (c == 5)   chk("d3_ready_oob", c, 32'(wr_ready3), 32'd1);
            if (c == 191) chk("d3_ready_end", c, 32'(wr_ready3), 32'd0);
            if (c == 192) chk("d3_sync",      c, 32'(sync3),     32'd1);
            if (c == 195 || c == 259 || c == 323 || c == 387) begin
                chk("d3_count", c, 32'(count3), 32'd0);
            end
            if (c == 195) chk("d3_en0", c, 32'(digit_en3), 32'b001);
            if (c == 259) chk("d3_en1", c, 32'(digit_en3), 32'b010);
            if (c == 323) chk("d3_en2", c, 32'(digit_en3), 32'b100);
            if (c == 387) chk("d3_en0b", c, 32'(digit_en3), 32'b001);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
